// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module  : ex_muldiv_unit
// Brief   : Iterative RV32M multiply/divide unit for the EX stage. One
//           shift-add or restoring-divide step per cycle with fixed latency.
//           The unit holds busy while working and returns a registered result
//           with a one-cycle done pulse.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_raw_q;
    logic [XLEN-1:0]   a_mag_q;
    logic [XLEN-1:0]   b_mag_q;
    logic              neg_q;
    logic              sa_q;
    logic              bzero_q;
    // mul: {partial product high, multiplier shifting out}; div: {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN:0]     div_rem;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   result_d;

    // Operand signedness and magnitudes for the op being presented
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_mag_q});
        div_rem   = div_ge ? (div_shift - {1'b0, b_mag_q}) : div_shift;
        if (f3_q[2]) begin
            acc_d = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection; divide overflow falls out of the
    // magnitude path naturally (|q| = 2^(XLEN-1) negates to itself, rem = 0)
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:         result_d = prod_fix[XLEN-1:0];
            3'b100, 3'b101: result_d = bzero_q ? '1 : quo_fix;
            3'b110, 3'b111: result_d = bzero_q ? a_raw_q : rem_fix;
            default:        result_d = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // Control FSM with registered busy/done/result and operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            a_raw_q  <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bzero_q  <= 1'b0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN-1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q  <= S_DONE;
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request
                    if (!flush && start) begin
                        state_q <= S_CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        f3_q    <= funct3;
                        a_raw_q <= op_a;
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        neg_q   <= sa ^ sb;
                        sa_q    <= sa;
                        bzero_q <= (op_b == '0);
                        acc_q   <= funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

`default_nettype wire
